// File: rtl/stage_phase_accumulator_if.sv
// ---------------------------------------------------------------------------
// stage_phase_accumulator_if
//
// Purpose: bundles the slot stream, the phase-step configuration port and the
// delayed phase/sideband outputs of stage_phase_accumulator into one interface
// so the block and whoever drives it share a single port list.
//
// Signals:
//   i_VoiceOperator         slot presented this cycle
//   i_AlgorithmWord         sideband word, delayed unchanged
//   i_NoteOn                gate level of the presented slot
//   i_Modulation            signed phase offset for the presented slot
//   i_PhaseStepWriteEnable  phase-step write strobe
//   i_PhaseStepWriteAddress slot whose phase step is written
//   i_PhaseStepWriteValue   unsigned 32-bit phase step
//   o_Ready                 high once the post-reset clear sweep is done
//   o_VoiceOperator         slot ID, delayed 3 cycles
//   o_AlgorithmWord         sideband word, delayed 3 cycles
//   o_NoteOn                gate level, delayed 3 cycles
//   o_Phase                 17-bit signed phase for the waveform generator
//
// Modports: master drives the inputs and observes the outputs, slave is the
// accumulator itself.
// ---------------------------------------------------------------------------
`ifndef VOICE_OPERATOR_ID
`define VOICE_OPERATOR_ID 7:0
`endif
`ifndef ALGORITHM_WORD
`define ALGORITHM_WORD 7:0
`endif

interface stage_phase_accumulator_if;
  logic [`VOICE_OPERATOR_ID] i_VoiceOperator;
  logic [`ALGORITHM_WORD]    i_AlgorithmWord;
  logic                      i_NoteOn;
  logic signed [15:0]        i_Modulation;
  logic                      i_PhaseStepWriteEnable;
  logic [`VOICE_OPERATOR_ID] i_PhaseStepWriteAddress;
  logic [31:0]               i_PhaseStepWriteValue;
  logic                      o_Ready;
  logic [`VOICE_OPERATOR_ID] o_VoiceOperator;
  logic [`ALGORITHM_WORD]    o_AlgorithmWord;
  logic                      o_NoteOn;
  logic signed [16:0]        o_Phase;

  // The upstream sequencer (or a bench) presents slots and configuration.
  modport master (
    output i_VoiceOperator, i_AlgorithmWord, i_NoteOn, i_Modulation,
    output i_PhaseStepWriteEnable, i_PhaseStepWriteAddress, i_PhaseStepWriteValue,
    input  o_Ready, o_VoiceOperator, o_AlgorithmWord, o_NoteOn, o_Phase
  );

  // The accumulator consumes slots and produces the delayed phase stream.
  modport slave (
    input  i_VoiceOperator, i_AlgorithmWord, i_NoteOn, i_Modulation,
    input  i_PhaseStepWriteEnable, i_PhaseStepWriteAddress, i_PhaseStepWriteValue,
    output o_Ready, o_VoiceOperator, o_AlgorithmWord, o_NoteOn, o_Phase
  );
endinterface

// File: rtl/stage_phase_accumulator.sv
// ---------------------------------------------------------------------------
// stage_phase_accumulator
//
// Purpose: time-multiplexed phase generator feeding stage_waveform_generator.
// Every RUN cycle one voice/operator slot is presented; its 32-bit phase
// accumulator advances by the slot's programmed phase step, a note-on rising
// edge hard-syncs it to zero, and the pre-increment phase plus the signed
// modulation input is emitted three cycles later together with the delayed
// sideband fields. After reset a sweep zeroes every accumulator and gate
// history before slots are accepted.
//
// Ports:
//   i_Clock    sole clock, posedge
//   i_Reset_n  synchronous active-low reset
//   bus        stage_phase_accumulator_if.slave (slot stream, phase-step
//              writes, o_Ready and the delayed phase/sideband outputs)
//
// Pipeline:
//   C1  register slot inputs, read PhaseStep/Accumulator/PrevNoteOn
//   C2  compute new accumulator and base phase, write back
//   C3  add modulation, register outputs
// ---------------------------------------------------------------------------
`ifndef VOICE_OPERATOR_ID
`define VOICE_OPERATOR_ID 7:0
`endif
`ifndef ALGORITHM_WORD
`define ALGORITHM_WORD 7:0
`endif

module stage_phase_accumulator #(
  parameter int NUM_SLOTS = 256
) (
  input logic                     i_Clock,
  input logic                     i_Reset_n,
  stage_phase_accumulator_if.slave bus
);

  localparam int ID_W = $clog2(NUM_SLOTS);
  localparam logic [ID_W-1:0] LAST_SLOT = ID_W'(NUM_SLOTS - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } SweepState;

  SweepState state;
  SweepState nextState;
  logic [ID_W-1:0] clearIdx;
  logic [ID_W-1:0] nextClearIdx;
  logic            clearWe;
  logic            readyReg;

  logic [31:0] phaseStep   [NUM_SLOTS];
  logic [31:0] accumulator [NUM_SLOTS];
  logic        prevNoteOn  [NUM_SLOTS];

  logic                   s1Valid;
  logic [ID_W-1:0]        s1Slot;
  logic [`ALGORITHM_WORD] s1Alg;
  logic                   s1NoteOn;
  logic signed [15:0]     s1Mod;
  logic [31:0]            s1Step;
  logic [31:0]            s1Acc;
  logic                   s1Prev;

  logic                   s2Valid;
  logic [ID_W-1:0]        s2Slot;
  logic [`ALGORITHM_WORD] s2Alg;
  logic                   s2NoteOn;
  logic signed [15:0]     s2Mod;
  logic [15:0]            s2Base;

  logic        forwardHit;
  logic        risingEdge;
  logic [31:0] newAcc;
  logic [15:0] basePhase;
  logic [16:0] phaseSum;

  // Sweep state register. Any cycle with reset low parks the FSM in CLEAR at
  // slot 0, so a reset in the middle of a sweep or of normal running always
  // restarts the full clear. Ready is a registered copy of "in RUN", which
  // makes it rise one cycle after the last slot has been cleared and keeps
  // slot acceptance aligned with the visible o_Ready.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state    <= CLEAR;
      clearIdx <= '0;
      readyReg <= 1'b0;
    end else begin
      state    <= nextState;
      clearIdx <= nextClearIdx;
      readyReg <= (state == RUN);
    end
  end

  // Sweep next-state logic: in CLEAR one slot is zeroed per cycle and the
  // final slot moves the FSM to RUN, where it stays until the next reset.
  always_comb begin
    nextState    = state;
    nextClearIdx = clearIdx;
    clearWe      = 1'b0;
    case (state)
      CLEAR: begin
        clearWe      = 1'b1;
        nextClearIdx = clearIdx + ID_W'(1);
        if (clearIdx == LAST_SLOT) begin
          nextState = RUN;
        end
      end
      RUN: begin
        nextState = RUN;
      end
      default: begin
        nextState = CLEAR;
      end
    endcase
  end

  assign bus.o_Ready = readyReg;

  // Phase-step configuration RAM. It has no reset and accepts writes in every
  // state so software can program steps while the block is held in reset.
  // Because the C1 read uses the value present before this edge, a write and
  // a read of the same slot in one cycle return the old step.
  always_ff @(posedge i_Clock) begin
    if (bus.i_PhaseStepWriteEnable) begin
      phaseStep[bus.i_PhaseStepWriteAddress] <= bus.i_PhaseStepWriteValue;
    end
  end

  // Accumulator and gate-history storage. The clear sweep owns the write
  // port while in CLEAR; in RUN the C2 stage writes back the updated state of
  // the slot it just processed. Nothing is written on a reset cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset_n) begin
      if (clearWe) begin
        accumulator[clearIdx] <= '0;
        prevNoteOn[clearIdx]  <= 1'b0;
      end else if (s1Valid) begin
        accumulator[s1Slot] <= newAcc;
        prevNoteOn[s1Slot]  <= s1NoteOn;
      end
    end
  end

  // A slot presented right behind the same slot would read storage before
  // the C2 write-back of that slot lands, so its state is taken straight from
  // the write-back path instead. A repeat at distance two already sees the
  // written value because its read happens one edge after that write.
  assign forwardHit = s1Valid && (s1Slot == ID_W'(bus.i_VoiceOperator));

  // C1: capture the presented slot and its stored state. Slots are accepted
  // only once o_Ready is high; otherwise the stage is filled with zeros so
  // the outputs read 0 throughout the clear sweep.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      s1Valid  <= 1'b0;
      s1Slot   <= '0;
      s1Alg    <= '0;
      s1NoteOn <= 1'b0;
      s1Mod    <= '0;
      s1Step   <= '0;
      s1Acc    <= '0;
      s1Prev   <= 1'b0;
    end else if (readyReg) begin
      s1Valid  <= 1'b1;
      s1Slot   <= ID_W'(bus.i_VoiceOperator);
      s1Alg    <= bus.i_AlgorithmWord;
      s1NoteOn <= bus.i_NoteOn;
      s1Mod    <= bus.i_Modulation;
      s1Step   <= phaseStep[bus.i_VoiceOperator];
      s1Acc    <= forwardHit ? newAcc : accumulator[bus.i_VoiceOperator];
      s1Prev   <= forwardHit ? s1NoteOn : prevNoteOn[bus.i_VoiceOperator];
    end else begin
      s1Valid  <= 1'b0;
      s1Slot   <= '0;
      s1Alg    <= '0;
      s1NoteOn <= 1'b0;
      s1Mod    <= '0;
      s1Step   <= '0;
      s1Acc    <= '0;
      s1Prev   <= 1'b0;
    end
  end

  // C2 arithmetic: a gate rising edge hard-syncs the slot, emitting phase 0
  // and restarting the accumulator at 0; otherwise the accumulator advances
  // modulo 2^32 and the emitted phase is its pre-increment upper half.
  always_comb begin
    risingEdge = s1NoteOn && !s1Prev;
    newAcc     = s1Acc + s1Step;
    basePhase  = s1Acc[31:16];
    if (risingEdge) begin
      newAcc    = '0;
      basePhase = '0;
    end
  end

  // C2 register: hold the base phase and the sideband for the final adder.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      s2Valid  <= 1'b0;
      s2Slot   <= '0;
      s2Alg    <= '0;
      s2NoteOn <= 1'b0;
      s2Mod    <= '0;
      s2Base   <= '0;
    end else if (s1Valid) begin
      s2Valid  <= 1'b1;
      s2Slot   <= s1Slot;
      s2Alg    <= s1Alg;
      s2NoteOn <= s1NoteOn;
      s2Mod    <= s1Mod;
      s2Base   <= basePhase;
    end else begin
      s2Valid  <= 1'b0;
      s2Slot   <= '0;
      s2Alg    <= '0;
      s2NoteOn <= 1'b0;
      s2Mod    <= '0;
      s2Base   <= '0;
    end
  end

  // The base phase is an unsigned 16-bit quantity and the modulation is
  // signed; both are widened to 17 bits and added with the carry dropped, so
  // only bits 15:0 are meaningful as a wrapped phase downstream.
  assign phaseSum = {1'b0, s2Base} + {s2Mod[15], s2Mod};

  // C3: register the outputs, forcing them to zero whenever no valid slot
  // is in the last stage.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      bus.o_VoiceOperator <= '0;
      bus.o_AlgorithmWord <= '0;
      bus.o_NoteOn        <= 1'b0;
      bus.o_Phase         <= '0;
    end else if (s2Valid) begin
      bus.o_VoiceOperator <= s2Slot;
      bus.o_AlgorithmWord <= s2Alg;
      bus.o_NoteOn        <= s2NoteOn;
      bus.o_Phase         <= phaseSum;
    end else begin
      bus.o_VoiceOperator <= '0;
      bus.o_AlgorithmWord <= '0;
      bus.o_NoteOn        <= 1'b0;
      bus.o_Phase         <= '0;
    end
  end

endmodule

// File: tb/tb_stage_phase_accumulator.sv
// ---------------------------------------------------------------------------
// tb_stage_phase_accumulator
//
// Purpose: self-checking bench for stage_phase_accumulator. A serial
// per-slot reference model predicts every RUN-cycle output; predictions are
// queued with the edge count at which they must appear and compared by a
// scoreboard monitor. Scenario tasks add direct checks of the key values.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_stage_phase_accumulator;

  localparam logic [7:0] IDLE_SLOT = 8'd200;

  typedef struct {
    int          due;
    int          tag;
    logic [7:0]  slot;
    logic [7:0]  alg;
    logic        noteOn;
    logic [16:0] phase;
  } ExpItem;

  logic i_Clock = 1'b0;
  logic i_Reset_n = 1'b0;

  stage_phase_accumulator_if bus();

  stage_phase_accumulator #(.NUM_SLOTS(256)) dut (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .bus       (bus)
  );

  ExpItem      expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          edgeCount = 0;
  int          tagCount = 0;
  logic [31:0] modelStep [256];
  logic [31:0] modelAcc  [256];
  logic        modelPrev [256];

  // Free-running clock.
  always #5 i_Clock = ~i_Clock;

  // Count active edges so queued predictions know when they are due.
  always @(posedge i_Clock) begin
    edgeCount = edgeCount + 1;
  end

  // Scoreboard monitor: on the falling edge, compare every prediction whose
  // due edge has arrived against the DUT outputs.
  always @(negedge i_Clock) begin : scoreboardMonitor
    ExpItem e;
    while (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
      e = expQ.pop_front();
      testsRun++;
      if (e.due != edgeCount) begin
        testsFailed++;
        $display("[TB] FAIL scoreboard item %0d: due at edge %0d, checked at %0d", e.tag, e.due, edgeCount);
      end else if (bus.o_Phase !== e.phase || bus.o_VoiceOperator !== e.slot ||
                   bus.o_AlgorithmWord !== e.alg || bus.o_NoteOn !== e.noteOn) begin
        testsFailed++;
        $display("[TB] FAIL scoreboard item %0d: got slot=%0d alg=%h noteOn=%b phase=%h, expected slot=%0d alg=%h noteOn=%b phase=%h",
                 e.tag, bus.o_VoiceOperator, bus.o_AlgorithmWord, bus.o_NoteOn, bus.o_Phase,
                 e.slot, e.alg, e.noteOn, e.phase);
      end
    end
  end

  // Present one slot for one cycle (optionally with a phase-step write),
  // advance the serial reference model and queue the expected output.
  task automatic applyStimulus(input logic [7:0] slot, input logic noteOn,
                               input logic signed [15:0] mod, input logic we,
                               input logic [7:0] wAddr, input logic [31:0] wVal);
    ExpItem      e;
    logic [31:0] acc;
    logic [31:0] nextAcc;
    logic [15:0] base;
    logic [7:0]  alg;
    alg = 8'($urandom);
    acc = modelAcc[slot];
    if (noteOn && !modelPrev[slot]) begin
      base    = 16'h0000;
      nextAcc = 32'h0;
    end else begin
      base    = acc[31:16];
      nextAcc = acc + modelStep[slot];
    end
    modelAcc[slot]  = nextAcc;
    modelPrev[slot] = noteOn;
    if (we) modelStep[wAddr] = wVal;
    e.due    = edgeCount + 3;
    e.tag    = tagCount;
    e.slot   = slot;
    e.alg    = alg;
    e.noteOn = noteOn;
    e.phase  = {1'b0, base} + {mod[15], mod};
    tagCount++;
    expQ.push_back(e);
    bus.i_VoiceOperator         = slot;
    bus.i_AlgorithmWord         = alg;
    bus.i_NoteOn                = noteOn;
    bus.i_Modulation            = mod;
    bus.i_PhaseStepWriteEnable  = we;
    bus.i_PhaseStepWriteAddress = wAddr;
    bus.i_PhaseStepWriteValue   = wVal;
    @(posedge i_Clock);
    #1;
    bus.i_PhaseStepWriteEnable = 1'b0;
  endtask

  task automatic applyIdle();
    applyStimulus(IDLE_SLOT, 1'b0, 16'sd0, 1'b0, 8'd0, 32'd0);
  endtask

  // Hold reset while programming every phase step, then release and measure
  // the clear sweep; outputs must stay zero with garbage slot inputs applied.
  task automatic test_reset();
    int lowCycles;
    logic [31:0] stepVal;
    i_Reset_n = 1'b0;
    bus.i_Modulation = 16'sh1234;
    for (int i = 0; i < 256; i++) begin
      case (i)
        3:       stepVal = 32'h0001_0000;
        5:       stepVal = 32'h0100_0000;
        7:       stepVal = 32'h4000_0000;
        9:       stepVal = 32'h0100_0000;
        default: stepVal = $urandom;
      endcase
      modelStep[i] = stepVal;
      modelAcc[i]  = 32'h0;
      modelPrev[i] = 1'b0;
      bus.i_PhaseStepWriteEnable  = 1'b1;
      bus.i_PhaseStepWriteAddress = 8'(i);
      bus.i_PhaseStepWriteValue   = stepVal;
      bus.i_VoiceOperator         = 8'($urandom);
      bus.i_AlgorithmWord         = 8'($urandom);
      bus.i_NoteOn                = 1'b1;
      @(posedge i_Clock);
      #1;
      testsRun++;
      if (bus.o_Phase !== 17'd0 || bus.o_NoteOn !== 1'b0 || bus.o_VoiceOperator !== 8'd0 ||
          bus.o_AlgorithmWord !== 8'd0 || bus.o_Ready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset outputs cycle %0d: got ready=%b phase=%h slot=%0d, expected all 0",
                 i, bus.o_Ready, bus.o_Phase, bus.o_VoiceOperator);
      end
    end
    bus.i_PhaseStepWriteEnable = 1'b0;
    i_Reset_n = 1'b1;
    lowCycles = 0;
    while (bus.o_Ready !== 1'b1 && lowCycles < 400) begin
      testsRun++;
      if (bus.o_Phase !== 17'd0 || bus.o_NoteOn !== 1'b0 || bus.o_VoiceOperator !== 8'd0 ||
          bus.o_AlgorithmWord !== 8'd0) begin
        testsFailed++;
        $display("[TB] FAIL sweep outputs cycle %0d: got phase=%h slot=%0d noteOn=%b, expected 0",
                 lowCycles, bus.o_Phase, bus.o_VoiceOperator, bus.o_NoteOn);
      end
      bus.i_VoiceOperator = 8'($urandom);
      bus.i_NoteOn        = 1'b1;
      lowCycles++;
      @(posedge i_Clock);
      #1;
    end
    testsRun++;
    if (lowCycles != 257) begin
      testsFailed++;
      $display("[TB] FAIL sweep length: got %0d ready-low cycles, expected 257", lowCycles);
    end
  endtask

  // Slot 5, step 0x0100_0000, gate held high: phase climbs by 0x0100 per
  // visit and wraps from 0xFF00 back to 0x0000.
  task automatic test_wrap();
    for (int v = 0; v < 258; v++) begin
      applyStimulus(8'd5, 1'b1, 16'sd0, 1'b0, 8'd0, 32'd0);
      applyStimulus(8'd100, 1'($urandom), 16'($urandom), 1'b0, 8'd0, 32'd0);
      applyStimulus(8'd101, 1'($urandom), 16'($urandom), 1'b0, 8'd0, 32'd0);
      if (v == 2 || v == 256 || v == 257) begin
        testsRun++;
        if (bus.o_Phase !== ((v == 2) ? 17'h00100 : (v == 256) ? 17'h0FF00 : 17'h00000)) begin
          testsFailed++;
          $display("[TB] FAIL slot5 wrap visit %0d: got %h", v, bus.o_Phase);
        end
      end
      applyStimulus(8'd102, 1'($urandom), 16'($urandom), 1'b0, 8'd0, 32'd0);
    end
  endtask

  // Slot 7 at base 0xC000: modulation -0x4000 gives 0x0_8000 and +0x5000
  // gives 0x1_1000 with bit 16 set.
  task automatic test_modulation();
    for (int k = 0; k < 4; k++) applyStimulus(8'd7, 1'b1, 16'sd0, 1'b0, 8'd0, 32'd0);
    applyStimulus(8'd7, 1'b1, -16'sh4000, 1'b0, 8'd0, 32'd0);
    applyIdle();
    applyIdle();
    testsRun++;
    if (bus.o_Phase !== 17'h08000) begin
      testsFailed++;
      $display("[TB] FAIL modulation negative: got %h, expected 08000", bus.o_Phase);
    end
    for (int k = 0; k < 3; k++) applyStimulus(8'd7, 1'b1, 16'sd0, 1'b0, 8'd0, 32'd0);
    applyStimulus(8'd7, 1'b1, 16'sh5000, 1'b0, 8'd0, 32'd0);
    applyIdle();
    applyIdle();
    testsRun++;
    if (bus.o_Phase !== 17'h11000) begin
      testsFailed++;
      $display("[TB] FAIL modulation positive: got %h, expected 11000", bus.o_Phase);
    end
  endtask

  // Slot 3 on consecutive cycles after its note-on visit, then at distance 2.
  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) applyStimulus(8'd3, 1'b1, 16'sd0, 1'b0, 8'd0, 32'd0);
    testsRun++;
    if (bus.o_Phase !== 17'h00000) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back first: got %h, expected 00000", bus.o_Phase);
    end
    applyIdle();
    testsRun++;
    if (bus.o_Phase !== 17'h00001) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back second: got %h, expected 00001", bus.o_Phase);
    end
    applyIdle();
    testsRun++;
    if (bus.o_Phase !== 17'h00002) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back third: got %h, expected 00002", bus.o_Phase);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'd3, 1'b1, 16'sd0, 1'b0, 8'd0, 32'd0);
      applyIdle();
    end
    applyIdle();
    testsRun++;
    if (bus.o_Phase !== 17'h00005) begin
      testsFailed++;
      $display("[TB] FAIL distance2 forward: got %h, expected 00005", bus.o_Phase);
    end
  endtask

  // Write a new step to slot 9 in the cycle slot 9 is read: that visit keeps
  // the old step, the following one uses the new step.
  task automatic test_step_write();
    applyStimulus(8'd9, 1'b1, 16'sd0, 1'b0, 8'd0, 32'd0);
    applyIdle();
    applyStimulus(8'd9, 1'b1, 16'sd0, 1'b1, 8'd9, 32'h0300_0000);
    applyIdle();
    applyStimulus(8'd9, 1'b1, 16'sd0, 1'b0, 8'd0, 32'd0);
    applyIdle();
    applyIdle();
    testsRun++;
    if (bus.o_Phase !== 17'h00100) begin
      testsFailed++;
      $display("[TB] FAIL read-first step: got %h, expected 00100", bus.o_Phase);
    end
    applyStimulus(8'd9, 1'b1, 16'sd0, 1'b0, 8'd0, 32'd0);
    applyIdle();
    applyIdle();
    testsRun++;
    if (bus.o_Phase !== 17'h00400) begin
      testsFailed++;
      $display("[TB] FAIL new step applied: got %h, expected 00400", bus.o_Phase);
    end
  endtask

  // Reset during RUN with live accumulators: the new sweep zeroes all state,
  // phase steps (including one written during reset) survive.
  task automatic test_reset_mid_run();
    int lowCycles;
    for (int s = 0; s < 256; s++) begin
      applyStimulus(8'(s), 1'($urandom), 16'($urandom), 1'b0, 8'd0, 32'd0);
    end
    expQ.delete();
    i_Reset_n = 1'b0;
    for (int s = 0; s < 256; s++) begin
      modelAcc[s]  = 32'h0;
      modelPrev[s] = 1'b0;
    end
    modelStep[50] = 32'h1234_5678;
    bus.i_PhaseStepWriteEnable  = 1'b1;
    bus.i_PhaseStepWriteAddress = 8'd50;
    bus.i_PhaseStepWriteValue   = 32'h1234_5678;
    bus.i_NoteOn                = 1'b1;
    repeat (5) begin
      @(posedge i_Clock);
      #1;
      bus.i_PhaseStepWriteEnable = 1'b0;
    end
    testsRun++;
    if (bus.o_Phase !== 17'd0 || bus.o_Ready !== 1'b0 || bus.o_NoteOn !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid-run reset outputs: got ready=%b phase=%h noteOn=%b, expected 0",
               bus.o_Ready, bus.o_Phase, bus.o_NoteOn);
    end
    i_Reset_n = 1'b1;
    lowCycles = 0;
    while (bus.o_Ready !== 1'b1 && lowCycles < 400) begin
      bus.i_VoiceOperator = 8'($urandom);
      lowCycles++;
      @(posedge i_Clock);
      #1;
    end
    testsRun++;
    if (lowCycles != 257) begin
      testsFailed++;
      $display("[TB] FAIL mid-run sweep length: got %0d ready-low cycles, expected 257", lowCycles);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < 256; s++) begin
        applyStimulus(8'(s), 1'b0, 16'sd0, 1'b0, 8'd0, 32'd0);
      end
    end
    applyStimulus(8'd5, 1'b0, 16'sd0, 1'b0, 8'd0, 32'd0);
    applyIdle();
    applyIdle();
    testsRun++;
    if (bus.o_Phase !== 17'h00200) begin
      testsFailed++;
      $display("[TB] FAIL step kept after reset: got %h, expected 00200", bus.o_Phase);
    end
  endtask

  // Test sequence and summary.
  initial begin
    bus.i_VoiceOperator         = 8'd0;
    bus.i_AlgorithmWord         = 8'd0;
    bus.i_NoteOn                = 1'b0;
    bus.i_Modulation            = 16'sd0;
    bus.i_PhaseStepWriteEnable  = 1'b0;
    bus.i_PhaseStepWriteAddress = 8'd0;
    bus.i_PhaseStepWriteValue   = 32'd0;
    $display("[TB] starting stage_phase_accumulator bench");
    test_reset();
    test_wrap();
    test_modulation();
    test_back_to_back();
    test_step_write();
    test_reset_mid_run();
    applyIdle();
    applyIdle();
    applyIdle();
    repeat (3) @(posedge i_Clock);
    @(negedge i_Clock);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: got %0d pending items, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/stage_phase_accumulator.md
# stage_phase_accumulator

Time-multiplexed phase generator that sits directly upstream of `stage_waveform_generator`. Each cycle it receives one voice/operator slot and advances that slot's 32-bit phase accumulator by its programmed phase step. It adds the phase-modulation input and emits the 17-bit signed phase with the slot's sideband fields, three cycles later. After reset it runs a clear sweep over all accumulator state before it accepts slots.

## Interface
- `NUM_SLOTS`, 256: number of voice/operator slots; slot ID width is `$clog2(NUM_SLOTS)` and equals the `` `VOICE_OPERATOR_ID `` width.
- `i_Clock` in 1: sole clock; all logic is on posedge.
- `i_Reset_n` in 1: reset; synchronous, active-low.
- `i_VoiceOperator` in `` `VOICE_OPERATOR_ID ``: slot presented this cycle.
- `i_AlgorithmWord` in `` `ALGORITHM_WORD ``: sideband, delayed unchanged.
- `i_NoteOn` in 1: slot's gate level this cycle.
- `i_Modulation` in 16 signed: phase offset for this slot, aligned with `i_VoiceOperator`.
- `i_PhaseStepWriteEnable` in 1: config write strobe.
- `i_PhaseStepWriteAddress` in `` `VOICE_OPERATOR_ID ``: slot to program.
- `i_PhaseStepWriteValue` in 32: unsigned phase step (2^32 = one cycle).
- `o_Ready` out 1: high once the clear sweep is done.
- `o_VoiceOperator`, `o_AlgorithmWord`, `o_NoteOn` out: sideband delayed 3 cycles.
- `o_Phase` out 17 signed: goes to `stage_waveform_generator` `i_Phase`.

## Operation
- Per-slot storage: `PhaseStep[NUM_SLOTS]` (32b), `Accumulator[NUM_SLOTS]` (32b), `PrevNoteOn[NUM_SLOTS]` (1b).
- State machine:
  - `CLEAR`, entered on any cycle with `i_Reset_n`=0. A counter walks slots 0..NUM_SLOTS-1, one per cycle, writing Accumulator=0 and PrevNoteOn=0.
  - After the last slot is written, the block enters `RUN` and `o_Ready` rises on the next cycle.
  - Reset asserted mid-sweep or mid-run restarts the sweep at slot 0.
- PhaseStep is not cleared by reset. Its contents after power-up are undefined until software writes them.
- Writes to PhaseStep are accepted in every state, including during reset.
- In `CLEAR`, slot inputs are ignored and pipeline valid bits are forced to 0: `o_NoteOn`=0, `o_Phase`=0, `o_VoiceOperator`=0, `o_AlgorithmWord`=0.
- `RUN` processing per slot s, with A = Accumulator[s] before update:
  - A rising edge is detected when `i_NoteOn`=1 and PrevNoteOn[s]=0.
  - On a rising edge: NewAcc = 0 and the emitted base phase is 0 (hard sync).
  - Otherwise: NewAcc = A + PhaseStep[s] mod 2^32 (wraps silently), and the base phase is A[31:16].
  - `o_Phase` = sign-extend-to-17(base phase as a 16b value, zero-extended) + sign-extend-to-17(`i_Modulation`). The result is 17-bit two's complement; the carry out of bit 16 is discarded.
  - Write back Accumulator[s]=NewAcc and PrevNoteOn[s]=`i_NoteOn`.
- The phase output is the pre-increment value, so the first sample after note-on is phase 0.
- Hazards:
  - When the same slot appears on consecutive cycles or at distance 2, the pipeline forwards the in-flight NewAcc and PrevNoteOn. Results must be identical to serial processing.
  - A PhaseStep write to slot s in the same cycle that s is read returns the old step (read-first). The new step applies from the next visit.

## Timing
- Latency is exactly 3 cycles from input to output for all fields.
  - C1: register inputs and read storage.
  - C2: compute NewAcc and base phase; write back.
  - C3: add modulation and register outputs.
- Throughput: one slot per cycle, with no stalls in `RUN`.
- Reset values (cycle after reset sampled low): all outputs 0, `o_Ready`=0.
- Clear sweep timing: with reset released at cycle 0, `o_Ready`=1 at cycle NUM_SLOTS+1. The first slot presented at that cycle is processed, and its output appears 3 cycles later.
- Config write takes effect on the slot's next read at least 1 cycle after the write.

## Test plan
- Reset, then release → `o_Ready` low for exactly 257 cycles (NUM_SLOTS=256), then high; all outputs 0 throughout.
- Slot 5: step=0x0100_0000, modulation 0, NoteOn 0→1 then held, visited every 256 cycles → `o_Phase` sequence 0, 0x0100, 0x0200, …; it wraps 0xFF00→0x0000 after 256 visits.
- Slot 7 at A[31:16]=0xC000 with modulation −0x4000 → `o_Phase`=0x0_8000; with modulation +0x5000 → 0x1_1000 (bit 16 set; only bits 15:0 matter downstream).
- Slot 3 presented on 3 consecutive cycles with step 0x0001_0000 after note-on → phases 0, 1, 2. This checks forwarding.
- Write step to slot 9 in the same cycle slot 9 is read → that visit uses the old step; the next visit uses the new one.
- Reset asserted during `RUN` with accumulators nonzero → after the new sweep, every slot's first output with modulation 0 is 0. PhaseStep values written before the reset are still in effect.
